fsm_sensor_responder: RTL

//  Plant-side counterpart of the motor-start controller FSM: consumes its f/g outputs and drives its x/y inputs.
//  On each f (start) pulse it emits the x pattern 1,0,1, waits for g, then answers (or withholds) y.
//  It checks the controller's g response and reports pass/fail.

---
 rtl/fsm_sensor_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fsm_sensor_responder.sv
// Plant-side responder for the motor-start controller.
// On each start pulse f it plays the x pattern 1,0,1, waits for the grant g,
// then either answers with y or withholds it, and checks how g behaves.
// The verdict is reported on the sticky pass/fail outputs.
module fsm_sensor_responder #(
  parameter int unsigned START_DLY = 2,
  parameter int unsigned G_TIMEOUT = 8,
  parameter int unsigned CHECK_CYC = 4,
  parameter int unsigned DENY_WIN  = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic y_ans,
  input  logic f,
  input  logic g,
  output logic x,
  output logic y,
  output logic busy,
  output logic pass,
  output logic fail
);

  localparam int unsigned MaxA = (START_DLY > G_TIMEOUT) ? START_DLY : G_TIMEOUT;
  localparam int unsigned MaxB = (CHECK_CYC > DENY_WIN) ? CHECK_CYC : DENY_WIN;
  localparam int unsigned MaxP = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW = (MaxP < 1) ? 1 : $clog2(MaxP + 1);

  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [3:0] {
    StIdle,
    StDly,
    StX1A,
    StX0,
    StX1B,
    StWaitG,
    StYHi,
    StNoY,
    StPass,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // State and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: abort beats restart, restart beats the normal sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (f) begin
      // f is level-sampled, so a held f keeps re-arming the start delay.
      if (START_DLY == 0) begin
        state_d = StX1A;
        cnt_d   = '0;
      end else begin
        state_d = StDly;
        cnt_d   = CntW'(START_DLY);
      end
    end else begin
      unique case (state_q)
        StDly: begin
          if (cnt_q == CntOne) begin
            state_d = StX1A;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StX1A: state_d = StX0;
        StX0:  state_d = StX1B;
        StX1B: begin
          state_d = StWaitG;
          cnt_d   = CntW'(G_TIMEOUT);
        end
        StWaitG: begin
          if (g) begin
            // y_ans is latched into the branch taken at the g rise.
            state_d = y_ans ? StYHi : StNoY;
            cnt_d   = y_ans ? CntW'(CHECK_CYC) : CntW'(DENY_WIN);
          end else if (cnt_q == CntOne) begin
            state_d = StFail;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StYHi: begin
          if (!g) begin
            state_d = StFail;
          end else if (cnt_q == CntOne) begin
            state_d = StPass;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StNoY: begin
          if (!g) begin
            state_d = StPass;
          end else if (cnt_q == CntOne) begin
            state_d = StFail;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          // Idle, Pass and Fail hold until a new start or an abort.
          state_d = state_q;
        end
      endcase
    end
  end

  // Moore output decode of the registered state.
  always_comb begin
    x    = (state_q == StX1A) || (state_q == StX1B);
    y    = (state_q == StYHi);
    pass = (state_q == StPass);
    fail = (state_q == StFail);
    busy = !((state_q == StIdle) || (state_q == StPass) || (state_q == StFail));
  end

endmodule
